// File: rtl/cpu_test_pkg.sv
// Shared definitions for the CPU run-and-check sequencer: FSM state
// encoding, the expectation-entry layout and default parameter values.
package cpu_test_pkg;

  localparam int DEF_XLEN         = 32;
  localparam int DEF_REG_ADDR_W   = 5;
  localparam int DEF_MEM_ADDR_W   = 8;
  localparam int DEF_NUM_CHECKS   = 8;
  localparam int DEF_RESET_CYCLES = 1;
  localparam int DEF_RUN_CYCLES   = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Entry layout at the default widths. check_table stores entries packed
  // in exactly this order {valid, is_mem, addr, value} at any width.
  typedef struct packed {
    logic                      valid;
    logic                      is_mem;
    logic [DEF_MEM_ADDR_W-1:0] addr;
    logic [DEF_XLEN-1:0]       value;
  } check_entry_t;

  // clog2 that never returns zero, so a one-entry table still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/check_table.sv
// Expectation table: NUM_CHECKS entries with a synchronous write port, an
// asynchronous read port and a per-entry valid bit. Reset clears every entry.
module check_table #(
  parameter int NUM_CHECKS = 8,
  parameter int MEM_ADDR_W = 8,
  parameter int XLEN       = 32,
  parameter int IDX_W      = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_is_mem,
  input  logic [MEM_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_value,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_is_mem,
  output logic [MEM_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_value
);

  localparam int EW = 2 + MEM_ADDR_W + XLEN;

  logic [EW-1:0] entry_q [NUM_CHECKS];
  logic [EW-1:0] entry_d [NUM_CHECKS];
  logic [EW-1:0] rd_entry;

  // Write port: a write always marks the entry valid.
  always_comb begin
    entry_d = entry_q;
    if (we && (int'(wr_idx) < NUM_CHECKS)) begin
      entry_d[wr_idx] = {1'b1, wr_is_mem, wr_addr, wr_value};
    end
  end

  // Table storage, fully cleared on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

  // Asynchronous read; out-of-range indices read as an invalid entry.
  always_comb begin
    rd_entry = '0;
    if (int'(rd_idx) < NUM_CHECKS) begin
      rd_entry = entry_q[rd_idx];
    end
    rd_valid  = rd_entry[EW-1];
    rd_is_mem = rd_entry[EW-2];
    rd_addr   = rd_entry[XLEN +: MEM_ADDR_W];
    rd_value  = rd_entry[XLEN-1:0];
  end

endmodule

// File: rtl/cpu_result_checker.sv
// Run-and-check sequencer for the single-cycle CPU: holds it in reset,
// lets it run for a fixed time, freezes it and compares register-file and
// data-memory contents against a loadable expectation table.
module cpu_result_checker
  import cpu_test_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int MEM_ADDR_W   = DEF_MEM_ADDR_W,
  parameter int NUM_CHECKS   = DEF_NUM_CHECKS,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int RUN_CYCLES   = DEF_RUN_CYCLES,
  parameter int IDX_W        = clog2_min1(NUM_CHECKS),
  parameter int ERR_W        = clog2_min1(NUM_CHECKS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  tbl_we,
  input  logic [IDX_W-1:0]      tbl_idx,
  input  logic                  tbl_is_mem,
  input  logic [MEM_ADDR_W-1:0] tbl_addr,
  input  logic [XLEN-1:0]       tbl_value,
  output logic                  cpu_reset,
  output logic                  cpu_hold,
  output logic [REG_ADDR_W-1:0] dbg_reg_addr,
  input  logic [XLEN-1:0]       dbg_reg_data,
  output logic [MEM_ADDR_W-1:0] dbg_mem_addr,
  input  logic [XLEN-1:0]       dbg_mem_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      error_count,
  output logic [IDX_W-1:0]      first_fail_idx,
  output logic [XLEN-1:0]       first_fail_value
);

  localparam int PH_W = clog2_min1(max3(RESET_CYCLES, RUN_CYCLES, NUM_CHECKS) + 1);

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [ERR_W-1:0] error_count_q, error_count_d;
  logic [IDX_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [XLEN-1:0]  first_fail_value_q, first_fail_value_d;

  logic                  tbl_wr;
  logic [IDX_W-1:0]      chk_idx;
  logic                  rd_valid;
  logic                  rd_is_mem;
  logic [MEM_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_value;
  logic [XLEN-1:0]       read_value;
  logic                  mismatch;

  // During CHECK the phase counter is the entry index k.
  assign chk_idx = phase_q[IDX_W-1:0];

  check_table #(
    .NUM_CHECKS (NUM_CHECKS),
    .MEM_ADDR_W (MEM_ADDR_W),
    .XLEN       (XLEN),
    .IDX_W      (IDX_W)
  ) u_table (
    .clock     (clock),
    .reset     (reset),
    .we        (tbl_wr),
    .wr_idx    (tbl_idx),
    .wr_is_mem (tbl_is_mem),
    .wr_addr   (tbl_addr),
    .wr_value  (tbl_value),
    .rd_idx    (chk_idx),
    .rd_valid  (rd_valid),
    .rd_is_mem (rd_is_mem),
    .rd_addr   (rd_addr),
    .rd_value  (rd_value)
  );

  // Debug reads are combinational, so the compare uses same-cycle data.
  assign read_value = rd_is_mem ? dbg_mem_data : dbg_reg_data;
  assign mismatch   = rd_valid && (read_value != rd_value);

  // Next-state, phase counting, table-write gating and error accounting.
  always_comb begin
    state_d            = state_q;
    phase_d            = phase_q;
    error_count_d      = error_count_q;
    first_fail_idx_d   = first_fail_idx_q;
    first_fail_value_d = first_fail_value_q;
    tbl_wr             = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Table only writable when not busy; a write with start lands first.
        tbl_wr = tbl_we;
        if (start) begin
          state_d = ST_RST;
          phase_d = '0;
        end
      end
      ST_RST: begin
        error_count_d      = '0;
        first_fail_idx_d   = '0;
        first_fail_value_d = '0;
        if (phase_q == PH_W'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_RUN: begin
        if (phase_q == PH_W'(RUN_CYCLES - 1)) begin
          state_d = ST_CHECK;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (error_count_q == '0) begin
            first_fail_idx_d   = chk_idx;
            first_fail_value_d = read_value;
          end
          error_count_d = error_count_q + ERR_W'(1);
        end
        if (phase_q == PH_W'(NUM_CHECKS - 1)) begin
          state_d = ST_DONE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // State and result registers; reset returns to IDLE with results cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      phase_q            <= '0;
      error_count_q      <= '0;
      first_fail_idx_q   <= '0;
      first_fail_value_q <= '0;
    end else begin
      state_q            <= state_d;
      phase_q            <= phase_d;
      error_count_q      <= error_count_d;
      first_fail_idx_q   <= first_fail_idx_d;
      first_fail_value_q <= first_fail_value_d;
    end
  end

  // Status and CPU control decoded from state; debug addresses only in CHECK.
  always_comb begin
    cpu_reset    = 1'b0;
    cpu_hold     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    pass         = 1'b0;
    dbg_reg_addr = '0;
    dbg_mem_addr = '0;
    unique case (state_q)
      ST_IDLE: cpu_reset = 1'b1;
      ST_RST: begin
        cpu_reset = 1'b1;
        busy      = 1'b1;
      end
      ST_RUN: busy = 1'b1;
      ST_CHECK: begin
        cpu_hold     = 1'b1;
        busy         = 1'b1;
        dbg_reg_addr = rd_addr[REG_ADDR_W-1:0];
        dbg_mem_addr = rd_addr;
      end
      ST_DONE: begin
        cpu_hold = 1'b1;
        done     = 1'b1;
        pass     = (error_count_q == '0);
      end
      default: cpu_reset = 1'b1;
    endcase
  end

  assign error_count      = error_count_q;
  assign first_fail_idx   = first_fail_idx_q;
  assign first_fail_value = first_fail_value_q;

endmodule

// File: tb/tb_cpu_result_checker.sv
// Directed bench for cpu_result_checker. A static register-file / memory
// image stands in for the frozen CPU behind the debug ports.
module tb_cpu_result_checker;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_ADDR_W = 8;
  localparam int NUM_CHECKS = 8;
  localparam int IDX_W      = 3;
  localparam int ERR_W      = 4;
  localparam int DONE_CYC   = 1 + 10 + 8 + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  reset;
  logic                  start;
  logic                  tbl_we;
  logic [IDX_W-1:0]      tbl_idx;
  logic                  tbl_is_mem;
  logic [MEM_ADDR_W-1:0] tbl_addr;
  logic [XLEN-1:0]       tbl_value;
  logic                  cpu_reset;
  logic                  cpu_hold;
  logic [REG_ADDR_W-1:0] dbg_reg_addr;
  logic [XLEN-1:0]       dbg_reg_data;
  logic [MEM_ADDR_W-1:0] dbg_mem_addr;
  logic [XLEN-1:0]       dbg_mem_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_W-1:0]      error_count;
  logic [IDX_W-1:0]      first_fail_idx;
  logic [XLEN-1:0]       first_fail_value;

  logic [XLEN-1:0] fake_regs [32];
  logic [XLEN-1:0] fake_mem  [256];

  assign dbg_reg_data = fake_regs[dbg_reg_addr];
  assign dbg_mem_data = fake_mem[dbg_mem_addr];

  cpu_result_checker #(
    .XLEN         (XLEN),
    .REG_ADDR_W   (REG_ADDR_W),
    .MEM_ADDR_W   (MEM_ADDR_W),
    .NUM_CHECKS   (NUM_CHECKS),
    .RESET_CYCLES (1),
    .RUN_CYCLES   (10)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .tbl_we           (tbl_we),
    .tbl_idx          (tbl_idx),
    .tbl_is_mem       (tbl_is_mem),
    .tbl_addr         (tbl_addr),
    .tbl_value        (tbl_value),
    .cpu_reset        (cpu_reset),
    .cpu_hold         (cpu_hold),
    .dbg_reg_addr     (dbg_reg_addr),
    .dbg_reg_data     (dbg_reg_data),
    .dbg_mem_addr     (dbg_mem_addr),
    .dbg_mem_data     (dbg_mem_data),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error_count      (error_count),
    .first_fail_idx   (first_fail_idx),
    .first_fail_value (first_fail_value)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic is_mem, input int addr, input logic [31:0] value);
    tbl_we     = 1'b1;
    tbl_idx    = IDX_W'(idx);
    tbl_is_mem = is_mem;
    tbl_addr   = MEM_ADDR_W'(addr);
    tbl_value  = value;
    tick();
    tbl_we = 1'b0;
  endtask

  // Start a run and follow it cycle by cycle. Cycle 1 is the first cycle
  // after the start edge. poke_at pulses tbl_we+start at that cycle;
  // rst_at pulses reset at that cycle and abandons the run (done_cyc=-1).
  task automatic run_test(input int poke_at, input int rst_at, output int done_cyc);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    done_cyc = 0;
    while (n <= 60) begin
      if (done) begin
        done_cyc = n;
        break;
      end
      check($sformatf("cpu_reset@%0d", n), 32'(cpu_reset), 32'(n <= 1));
      check($sformatf("cpu_hold@%0d", n), 32'(cpu_hold), 32'(n >= 12));
      check($sformatf("busy@%0d", n), 32'(busy), 32'd1);
      if (n == 2) check("err_cleared_in_rst", 32'(error_count), 32'd0);
      if (n == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        done_cyc = -1;
        break;
      end
      if (n == poke_at) begin
        tbl_we     = 1'b1;
        tbl_idx    = 3'd1;
        tbl_is_mem = 1'b0;
        tbl_addr   = 8'd4;
        tbl_value  = 32'd20;
        start      = 1'b1;
        tick();
        tbl_we = 1'b0;
        start  = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    if (done_cyc == 0) check("run_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_done(input string tag, input int dc, input logic exp_pass,
                            input int exp_err, input int exp_idx, input logic [31:0] exp_val);
    check({tag, "_done_cycle"}, 32'(dc), 32'(DONE_CYC));
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_err"}, 32'(error_count), 32'(exp_err));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (exp_err != 0) begin
      check({tag, "_ff_idx"}, 32'(first_fail_idx), 32'(exp_idx));
      check({tag, "_ff_val"}, first_fail_value, exp_val);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    reset      = 1'b1;
    start      = 1'b0;
    tbl_we     = 1'b0;
    tbl_idx    = '0;
    tbl_is_mem = 1'b0;
    tbl_addr   = '0;
    tbl_value  = '0;
    for (int i = 0; i < 32; i++)  fake_regs[i] = 32'hffff_0000 | 32'(i);
    for (int i = 0; i < 256; i++) fake_mem[i]  = 32'hee00_0000 | 32'(i);
    // Stray contents at index 0: an invalid (all-zero) entry would mismatch if counted.
    fake_regs[0] = 32'hdead_beef;
    fake_mem[0]  = 32'h0bad_0bad;
    fake_regs[1] = 32'd0;
    fake_regs[4] = 32'd20;
    fake_regs[5] = 32'd16;
    fake_regs[6] = 32'd20;
    fake_regs[7] = 32'd8;
    fake_mem[1]  = 32'd20;

    repeat (3) tick();
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_ff_idx", 32'(first_fail_idx), 32'd0);
    check("rst_ff_val", first_fail_value, 32'd0);
    check("rst_dbg_reg_addr", 32'(dbg_reg_addr), 32'd0);
    check("rst_dbg_mem_addr", 32'(dbg_mem_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Pass run.
    write_entry(0, 1'b0, 1, 32'd0);
    write_entry(1, 1'b0, 4, 32'd20);
    write_entry(2, 1'b0, 5, 32'd16);
    write_entry(3, 1'b0, 6, 32'd20);
    write_entry(4, 1'b0, 7, 32'd8);
    write_entry(5, 1'b1, 1, 32'd20);
    run_test(0, 0, dc);
    check_done("pass_run", dc, 1'b1, 0, 0, 32'd0);

    // Single fail at idx 2.
    write_entry(2, 1'b0, 5, 32'd17);
    run_test(0, 0, dc);
    check_done("single_fail", dc, 1'b0, 1, 2, 32'd16);

    // Rerun from DONE with idx 2 fixed.
    write_entry(2, 1'b0, 5, 32'd16);
    run_test(0, 0, dc);
    check_done("rerun", dc, 1'b1, 0, 0, 32'd0);

    // Multiple fails at idx 1 and 4; entries 6-7 stay invalid.
    write_entry(1, 1'b0, 4, 32'd21);
    write_entry(4, 1'b0, 7, 32'd9);
    run_test(0, 0, dc);
    check_done("multi_fail", dc, 1'b0, 2, 1, 32'd20);

    // tbl_we + start during RUN: dropped, so results and timing are unchanged.
    run_test(5, 0, dc);
    check_done("busy_protect", dc, 1'b0, 2, 1, 32'd20);

    // Reset while checking entry k=3 (cycle 12+3).
    run_test(0, 15, dc);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_err", 32'(error_count), 32'd0);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd0);

    // Empty table afterwards: every entry invalid, so the run passes.
    run_test(0, 0, dc);
    check_done("empty_table", dc, 1'b1, 0, 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_result_checker.md
# cpu_result_checker

Synthesizable run-and-check sequencer that wraps the single-cycle `cpu` for self-checking simulation and on-board bring-up. It holds the CPU in reset, releases it for a fixed number of cycles, freezes it, then reads registers and data memory through debug ports. Each read is compared against a loadable table of expected values, and the block reports pass/fail, error count and the first failing entry. It replaces ad-hoc hierarchical `$display` checks with a parametrised table of NUM_CHECKS entries and real error accounting.

## Interface
- XLEN, 32, datapath / compare width
- REG_ADDR_W, 5, register-file index width
- MEM_ADDR_W, 8, data-memory word index width
- NUM_CHECKS, 8, expectation-table depth (≥1); IDX_W = clog2(NUM_CHECKS), ERR_W = clog2(NUM_CHECKS+1)
- RESET_CYCLES, 1, cycles CPU reset is held after start (≥1)
- RUN_CYCLES, 10, cycles CPU runs before freeze (≥1)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; clears all state and table
- start  in  1  begin a run; sampled only in IDLE or DONE
- tbl_we  in  1  write table entry; ignored while busy
- tbl_idx  in  IDX_W  entry index
- tbl_is_mem  in  1  0 = register check, 1 = data-memory check
- tbl_addr  in  MEM_ADDR_W  register index (low REG_ADDR_W bits) or memory word index
- tbl_value  in  XLEN  expected value
- cpu_reset  out  1  drives CPU reset
- cpu_hold  out  1  CPU clock-enable inverse (1 = frozen)
- dbg_reg_addr  out  REG_ADDR_W  register-file debug read address
- dbg_reg_data  in  XLEN  asynchronous read data
- dbg_mem_addr  out  MEM_ADDR_W  data-memory debug read address
- dbg_mem_data  in  XLEN  asynchronous read data
- busy, done, pass  out  1  status
- error_count  out  ERR_W  mismatches in last run
- first_fail_idx  out  IDX_W  first mismatching entry
- first_fail_value  out  XLEN  value actually read at that entry

## Operation
- FSM states: IDLE → RST → RUN → CHECK → DONE. DONE + start → RST. Any state + reset → IDLE.
- IDLE: cpu_reset=1, cpu_hold=0, busy=0, done=0. Table writable.
- RST: cpu_reset=1 for RESET_CYCLES. Clears error_count, first_fail_idx and first_fail_value.
- RUN: cpu_reset=0, cpu_hold=0 for RUN_CYCLES.
- CHECK: cpu_hold=1, one entry per cycle, k = 0..NUM_CHECKS-1.
  - Both dbg addresses are driven from entry k.
  - The read value is muxed by is_mem.
  - For valid entries, mismatch is registered at the cycle end.
  - Invalid (never-written) entries still consume their cycle but never count.
- On first mismatch (error_count==0): capture k and the read value. Then increment error_count. No saturation needed.
- DONE: cpu_hold=1, cpu_reset=0 (CPU state stays inspectable), done=1, pass=(error_count==0). Table is retained for the next start.
- tbl_we in IDLE/DONE writes the entry and sets its valid bit. tbl_we while busy is dropped; the table is unchanged.
- start while busy is ignored. start and tbl_we together in IDLE: the write lands and the run starts; the new entry is checked.
- Reset values: cpu_reset=1, all other outputs 0, all valid bits 0.

## Timing
- start high at edge E0 in IDLE:
  - RST occupies cycles 1..RESET_CYCLES.
  - RUN occupies the next RUN_CYCLES.
  - CHECK occupies the next NUM_CHECKS.
  - done=1 from cycle RESET_CYCLES+RUN_CYCLES+NUM_CHECKS+1 onward.
- error_count is final when done rises. pass is valid only while done=1.
- Debug reads are combinational (same-cycle data). The compare is registered: one cycle per entry, no pipelining.
- Reset mid-run: the next cycle is IDLE with cpu_reset=1. The table is cleared and no partial result is kept.

## Structure
- Shared package/header `cpu_test_pkg`:
  - state encoding (IDLE=0, RST=1, RUN=2, CHECK=3, DONE=4)
  - entry layout {valid, is_mem, addr, value}
  - default parameter constants
- One sub-module: `check_table`, a NUM_CHECKS-deep register array with a sync write port, an async read port and a per-entry valid bit, cleared on reset.
- Phase counter width is clog2(max(RESET_CYCLES, RUN_CYCLES, NUM_CHECKS)+1).

## Test plan
- Pass run:
  - Load x1=0, x4=20, x5=16, x6=20, x7=8, mem[1]=20; start.
  - Required: done at cycle 1+10+8+1=20, pass=1, error_count=0.
- Single fail: expect x5=17 at idx 2 → error_count=1, first_fail_idx=2, first_fail_value=16, pass=0.
- Multiple fails: idx 1 and 4 wrong → error_count=2, first_fail_idx=1. Invalid entries 6–7 never counted.
- Busy protection: tbl_we and start asserted during RUN → table unchanged, no restart, done cycle unchanged.
- Reset mid-CHECK (k=3):
  - Next cycle: IDLE, cpu_reset=1, error_count=0.
  - A following start with an empty table gives pass=1.
- Rerun from DONE:
  - Fix idx 2 to 16 and start again.
  - Required: error_count clears in RST, final pass=1.
